// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bus of uart_tx_arbiter: pending-request levels, their bytes,
// and the grant/ack returned to the requesters.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_LEN = 8
);
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*DATA_LEN-1:0] req_data;
    logic [NUM_REQ-1:0]          grant;
    logic [NUM_REQ-1:0]          ack;

    modport master (output req, output req_data, input grant, input ack);
    modport slave  (input req, input req_data, output grant, output ack);
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ requesters: picks a winner, latches its byte,
// pulses send_sig and acks the owner. Define UART_ARB_FIXED_PRIO_EN for fixed priority.
module uart_tx_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_LEN = 8
) (
    input  logic                clk_i,
    input  logic                reset_i,
    uart_tx_arbiter_if.slave    bus,
    output logic                arb_busy_o,
    output logic                send_sig_o,
    output logic [DATA_LEN-1:0] data_o,
    input  logic                tx_busy_i,
    input  logic                tx_done_i
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic                send_q, send_d;
    logic                arb_busy_q, arb_busy_d;
    logic [DATA_LEN-1:0] data_q, data_d;
    logic                win_found_s;
    logic [PTR_W-1:0]    win_idx_s;
    logic [DATA_LEN-1:0] win_data_s;
`ifndef UART_ARB_FIXED_PRIO_EN
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PTR_W:0]      cand_sum_s;
    logic [PTR_W:0]      cand_s;
    logic                hit_s;
`endif

    // Winner selection among the pending requests
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = {PTR_W{1'b0}};
`ifdef UART_ARB_FIXED_PRIO_EN
        // Scan downward so the lowest set index is the one left standing.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            win_idx_s   = bus.req[i] ? PTR_W'(i) : win_idx_s;
            win_found_s = win_found_s | bus.req[i];
        end
`else
        cand_sum_s = {(PTR_W+1){1'b0}};
        cand_s     = {(PTR_W+1){1'b0}};
        hit_s      = 1'b0;
        // Search rr_ptr+1, rr_ptr+2, ... wrapping at NUM_REQ; first hit wins.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_sum_s  = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            cand_s      = (cand_sum_s >= (PTR_W+1)'(NUM_REQ)) ?
                          (cand_sum_s - (PTR_W+1)'(NUM_REQ)) : cand_sum_s;
            hit_s       = !win_found_s && bus.req[cand_s[PTR_W-1:0]];
            win_idx_s   = hit_s ? cand_s[PTR_W-1:0] : win_idx_s;
            win_found_s = win_found_s | hit_s;
        end
`endif
    end

    // Byte of the selected requester
    always_comb begin
        win_data_s = {DATA_LEN{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            win_data_s = (win_idx_s == PTR_W'(i)) ? bus.req_data[i*DATA_LEN +: DATA_LEN] : win_data_s;
        end
    end

    // Next-state and registered-output logic of the transfer FSM
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ack_d   = {NUM_REQ{1'b0}};
        send_d  = 1'b0;
        data_d  = data_q;
`ifndef UART_ARB_FIXED_PRIO_EN
        rr_ptr_d = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_found_s) begin
                    grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_s;
                    data_d  = win_data_s;
                    send_d  = 1'b1;
                    state_d = WAIT_BUSY;
`ifndef UART_ARB_FIXED_PRIO_EN
                    rr_ptr_d = win_idx_s;
`endif
                end else begin
                    grant_d = {NUM_REQ{1'b0}};
                end
            end
            WAIT_BUSY: begin
                // A done seen before busy still completes the transfer.
                if (tx_done_i) begin
                    ack_d   = grant_q;
                    grant_d = {NUM_REQ{1'b0}};
                    state_d = GAP;
                end else if (tx_busy_i) begin
                    state_d = WAIT_DONE;
                end else begin
                    state_d = WAIT_BUSY;
                end
            end
            WAIT_DONE: begin
                if (tx_done_i) begin
                    ack_d   = grant_q;
                    grant_d = {NUM_REQ{1'b0}};
                    state_d = GAP;
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                grant_d = {NUM_REQ{1'b0}};
            end
        endcase
        arb_busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            grant_q    <= {NUM_REQ{1'b0}};
            ack_q      <= {NUM_REQ{1'b0}};
            send_q     <= 1'b0;
            arb_busy_q <= 1'b0;
            data_q     <= {DATA_LEN{1'b0}};
`ifndef UART_ARB_FIXED_PRIO_EN
            rr_ptr_q   <= PTR_W'(NUM_REQ - 1);
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            send_q     <= send_d;
            arb_busy_q <= arb_busy_d;
            data_q     <= data_d;
`ifndef UART_ARB_FIXED_PRIO_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end

    assign bus.grant  = grant_q;
    assign bus.ack    = ack_q;
    assign send_sig_o = send_q;
    assign arb_busy_o = arb_busy_q;
    assign data_o     = data_q;
endmodule
